// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store unit between EX/MEM and a big-endian,
// byte-addressed data memory with combinational 32-bit reads and clocked
// 32-bit writes. Extracts and extends sub-word loads, turns byte/half stores
// into a two-cycle read-modify-write, and optionally traps misaligned accesses.
//
// Configuration macro: MAU_MISALIGN_TRAP_EN
//   defined   - misaligned word/half accesses are suppressed and flagged.
//   undefined - misaligned is tied to 0 and low offset bits are forced to
//               natural alignment, so the access proceeds.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   req_*             memory operation held in EX/MEM (valid, write, size,
//                     unsigned, byte address, right-justified store data)
//   stall             hold EX/MEM and earlier stages (combinational)
//   load_valid/data   registered, extended load result (1-cycle latency)
//   misaligned        registered one-cycle alignment error pulse
//   dm_*              data memory port (read/write enables, word address,
//                     write word, combinational read word)
module mem_access_unit #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              stall,
    output logic              load_valid,
    output logic [31:0]       load_data,
    output logic              misaligned,
    output logic              dm_memRead,
    output logic              dm_memWrite,
    output logic [ADDR_W-1:0] dm_address,
    output logic [31:0]       dm_writeData,
    input  logic [31:0]       dm_readData
);

    localparam int unsigned DATA_W = 32;

    typedef enum logic {
        IDLE   = 1'b0,
        RMW_WR = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   merge_q, merge_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                load_valid_q, load_valid_d;
    logic [DATA_W-1:0]   load_data_q, load_data_d;
    logic                misaligned_q, misaligned_d;

    // Size decode; reserved size 2'b11 behaves as a word.
    logic is_word, is_half, is_byte;
    assign is_word = req_size[1];
    assign is_half = (req_size == 2'b01);
    assign is_byte = (req_size == 2'b00);

    logic [ADDR_W-1:0] word_addr;
    assign word_addr = {req_addr[ADDR_W-1:2], 2'b00};

    // Effective byte offset and alignment error.
    logic [1:0] offset;
    logic       misalign;
`ifdef MAU_MISALIGN_TRAP_EN
    assign offset   = req_addr[1:0];
    assign misalign = (is_word && (req_addr[1:0] != 2'b00)) ||
                      (is_half && req_addr[0]);
`else
    always_comb begin
        if (is_word)      offset = 2'b00;
        else if (is_half) offset = {req_addr[1], 1'b0};
        else              offset = req_addr[1:0];
    end
    assign misalign = 1'b0;
`endif

    // Big-endian lane selection from the read word.
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    always_comb begin
        case (offset)
            2'd0:    byte_lane = dm_readData[31:24];
            2'd1:    byte_lane = dm_readData[23:16];
            2'd2:    byte_lane = dm_readData[15:8];
            default: byte_lane = dm_readData[7:0];
        endcase
        half_lane = offset[1] ? dm_readData[15:0] : dm_readData[31:16];
    end

    // Sign/zero-extended load result.
    logic [DATA_W-1:0] load_ext;
    always_comb begin
        if (is_byte)
            load_ext = {{24{~req_unsigned & byte_lane[7]}}, byte_lane};
        else if (is_half)
            load_ext = {{16{~req_unsigned & half_lane[15]}}, half_lane};
        else
            load_ext = dm_readData;
    end

    // Read word with the target lane replaced by the store data.
    logic [DATA_W-1:0] merged;
    always_comb begin
        merged = dm_readData;
        if (is_byte) begin
            case (offset)
                2'd0:    merged[31:24] = req_wdata[7:0];
                2'd1:    merged[23:16] = req_wdata[7:0];
                2'd2:    merged[15:8]  = req_wdata[7:0];
                default: merged[7:0]   = req_wdata[7:0];
            endcase
        end else if (offset[1]) begin
            merged[15:0] = req_wdata[15:0];
        end else begin
            merged[31:16] = req_wdata[15:0];
        end
    end

    // Next state and memory-side controls. Reset suppresses every side
    // effect, including the pending write of an interrupted read-modify-write.
    always_comb begin
        state_d      = state_q;
        merge_d      = merge_q;
        addr_d       = addr_q;
        load_valid_d = 1'b0;
        load_data_d  = load_data_q;
        misaligned_d = 1'b0;
        stall        = 1'b0;
        dm_memRead   = 1'b0;
        dm_memWrite  = 1'b0;
        dm_writeData = '0;
        dm_address   = word_addr;
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        if (misalign) begin
                            misaligned_d = 1'b1;
                        end else if (!req_write) begin
                            dm_memRead   = 1'b1;
                            load_valid_d = 1'b1;
                            load_data_d  = load_ext;
                        end else if (is_word) begin
                            dm_memWrite  = 1'b1;
                            dm_writeData = req_wdata;
                        end else begin
                            dm_memRead = 1'b1;
                            stall      = 1'b1;
                            merge_d    = merged;
                            addr_d     = word_addr;
                            state_d    = RMW_WR;
                        end
                    end
                end
                RMW_WR: begin
                    // Request inputs are ignored; the captured address is used.
                    dm_address   = addr_q;
                    dm_memWrite  = 1'b1;
                    dm_writeData = merge_q;
                    state_d      = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            merge_q      <= '0;
            addr_q       <= '0;
            load_valid_q <= 1'b0;
            load_data_q  <= '0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            merge_q      <= merge_d;
            addr_q       <= addr_d;
            load_valid_q <= load_valid_d;
            load_data_q  <= load_data_d;
            misaligned_q <= misaligned_d;
        end
    end

    assign load_valid = load_valid_q;
    assign load_data  = load_data_q;
    assign misaligned = misaligned_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed testbench for mem_access_unit with a small behavioural data memory.
module tb_mem_access_unit;

    localparam int unsigned ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              stall;
    logic              load_valid;
    logic [31:0]       load_data;
    logic              misaligned;
    logic              dm_memRead;
    logic              dm_memWrite;
    logic [ADDR_W-1:0] dm_address;
    logic [31:0]       dm_writeData;
    logic [31:0]       dm_readData;

    int n_tests = 0;
    int n_fail  = 0;

    // Combinational outputs captured mid-cycle by do_cycle.
    logic        s_stall, s_rd, s_wr;
    logic [31:0] s_wdata;

    logic [31:0] mem [0:255];
    logic [31:0] exp_word;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .stall        (stall),
        .load_valid   (load_valid),
        .load_data    (load_data),
        .misaligned   (misaligned),
        .dm_memRead   (dm_memRead),
        .dm_memWrite  (dm_memWrite),
        .dm_address   (dm_address),
        .dm_writeData (dm_writeData),
        .dm_readData  (dm_readData)
    );

    // Data memory: combinational read, write on the clock edge.
    assign dm_readData = mem[dm_address[9:2]];
    always @(posedge clk) begin
        if (dm_memWrite) mem[dm_address[9:2]] <= dm_writeData;
    end

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drive one request cycle (entered just after a rising edge), capture the
    // combinational outputs, then advance past the next rising edge.
    task automatic do_cycle(input logic v, input logic w, input logic [1:0] sz,
                            input logic u, input logic [31:0] a,
                            input logic [31:0] wd);
        req_valid    = v;
        req_write    = w;
        req_size     = sz;
        req_unsigned = u;
        req_addr     = a;
        req_wdata    = wd;
        #3;
        s_stall = stall;
        s_rd    = dm_memRead;
        s_wr    = dm_memWrite;
        s_wdata = dm_writeData;
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'h40] = 32'h112233F4;   // address 0x100
        rst = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst load_valid", 32'(load_valid), 32'h0);
        check_eq("rst load_data",  load_data,        32'h0);
        check_eq("rst misaligned", 32'(misaligned), 32'h0);
        rst = 1'b0;

        // Idle: nothing driven to memory.
        do_cycle(1'b0, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
        check_eq("idle ctrl", {29'h0, s_stall, s_rd, s_wr}, 32'h0);
        check_eq("idle wdata", s_wdata, 32'h0);

        // Loads from 0x100 = 0x112233F4.
        do_cycle(1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
        check_eq("lw ctrl", {29'h0, s_stall, s_rd, s_wr}, 32'h2);
        check_eq("lw valid", 32'(load_valid), 32'h1);
        check_eq("lw data", load_data, 32'h112233F4);
        do_cycle(1'b1, 1'b0, 2'b00, 1'b0, 32'h103, 32'h0);
        check_eq("lb 103", load_data, 32'hFFFFFFF4);
        do_cycle(1'b1, 1'b0, 2'b00, 1'b1, 32'h103, 32'h0);
        check_eq("lbu 103", load_data, 32'h000000F4);
        do_cycle(1'b1, 1'b0, 2'b00, 1'b0, 32'h100, 32'h0);
        check_eq("lb 100", load_data, 32'h00000011);
        do_cycle(1'b1, 1'b0, 2'b01, 1'b0, 32'h102, 32'h0);
        check_eq("lh 102", load_data, 32'h000033F4);
        do_cycle(1'b1, 1'b0, 2'b01, 1'b0, 32'h100, 32'h0);
        check_eq("lh 100", load_data, 32'h00001122);
        do_cycle(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        check_eq("lv pulse end", 32'(load_valid), 32'h0);

        // sb 0x101: one stall cycle, then the merged write.
        do_cycle(1'b1, 1'b1, 2'b00, 1'b0, 32'h101, 32'h000000AA);
        check_eq("sb c1 ctrl", {29'h0, s_stall, s_rd, s_wr}, 32'h6);
        do_cycle(1'b1, 1'b1, 2'b00, 1'b0, 32'h101, 32'h000000AA);
        check_eq("sb c2 ctrl", {29'h0, s_stall, s_rd, s_wr}, 32'h1);
        check_eq("sb c2 wdata", s_wdata, 32'h11AA33F4);
        check_eq("sb mem", mem[8'h40], 32'h11AA33F4);
        do_cycle(1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
        check_eq("lw after sb", load_data, 32'h11AA33F4);

        // sh 0x103: trapped, or forced to lane [15:0].
        do_cycle(1'b1, 1'b1, 2'b01, 1'b0, 32'h103, 32'h00005566);
`ifdef MAU_MISALIGN_TRAP_EN
        check_eq("sh mis ctrl", {29'h0, s_stall, s_rd, s_wr}, 32'h0);
        check_eq("sh mis flag", 32'(misaligned), 32'h1);
        check_eq("sh mis lv", 32'(load_valid), 32'h0);
        exp_word = 32'h11AA33F4;
`else
        check_eq("sh fix c1", {29'h0, s_stall, s_rd, s_wr}, 32'h6);
        check_eq("sh fix flag", 32'(misaligned), 32'h0);
        do_cycle(1'b1, 1'b1, 2'b01, 1'b0, 32'h103, 32'h00005566);
        check_eq("sh fix wdata", s_wdata, 32'h11AA5566);
        exp_word = 32'h11AA5566;
`endif
        do_cycle(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        check_eq("sh 103 mem", mem[8'h40], exp_word);
        check_eq("mis pulse end", 32'(misaligned), 32'h0);

        // sh 0x100 interrupted by reset in the write cycle.
        do_cycle(1'b1, 1'b1, 2'b01, 1'b0, 32'h100, 32'h00007788);
        check_eq("sh rst c1", 32'(s_stall), 32'h1);
        rst = 1'b1;
        do_cycle(1'b1, 1'b1, 2'b01, 1'b0, 32'h100, 32'h00007788);
        check_eq("sh rst no wr", 32'(s_wr), 32'h0);
        rst = 1'b0;
        check_eq("sh rst mem", mem[8'h40], exp_word);
        check_eq("sh rst outs", {30'h0, load_valid, misaligned}, 32'h0);
        check_eq("sh rst ldata", load_data, 32'h0);
        do_cycle(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        check_eq("sh rst idle", {29'h0, s_stall, s_rd, s_wr}, 32'h0);

        // Back-to-back sw then lw (reserved size behaves as word).
        do_cycle(1'b1, 1'b1, 2'b10, 1'b0, 32'h104, 32'hDEADBEEF);
        check_eq("sw ctrl", {29'h0, s_stall, s_rd, s_wr}, 32'h1);
        check_eq("sw wdata", s_wdata, 32'hDEADBEEF);
        do_cycle(1'b1, 1'b0, 2'b11, 1'b0, 32'h104, 32'h0);
        check_eq("lw 104 stall", 32'(s_stall), 32'h0);
        check_eq("lw 104 data", load_data, 32'hDEADBEEF);
        check_eq("lw 104 valid", 32'(load_valid), 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
